// File: rtl/game_pkg.sv
// Shared game definitions: scene encodings, playfield limits, shot spawn/retire
// rows and the coordinate width used by the player, enemy and shot blocks.
package game_pkg;

    localparam int unsigned COORD_W = 9;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        SCENE_TITLE = 2'b00,
        SCENE_PLAY  = 2'b01,
        SCENE_OVER  = 2'b10
    } scene_e;

    localparam int unsigned X_MIN   = 64;
    localparam int unsigned X_MAX   = 208;
    localparam int unsigned SPAWN_Y = 220;
    localparam int unsigned Y_TOP   = 16;

endpackage

// File: rtl/shot_slot.sv
// One shot slot: holds live flag and x/y, applies kill > scene-clear > spawn > move
// priority, and reports whether the shot covers the renderer query pixel.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   clk_en          game tick
//   play            scene is PLAY
//   spawn           this slot is the spawn target this tick
//   kill            retire request for this slot (any cycle)
//   spawn_x         player x captured at spawn
//   qx, qy          renderer query pixel
//   active, x, y    slot state (registered)
//   cover_c         combinational: live shot covers (qx,qy)
module shot_slot #(
    parameter int unsigned SPAWN_Y = game_pkg::SPAWN_Y,
    parameter int unsigned Y_TOP   = game_pkg::Y_TOP,
    parameter int unsigned SPEED   = 2,
    parameter int unsigned SHOT_W  = 2,
    parameter int unsigned SHOT_H  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clk_en,
    input  logic                        play,
    input  logic                        spawn,
    input  logic                        kill,
    input  logic [game_pkg::COORD_W-1:0] spawn_x,
    input  logic [game_pkg::COORD_W-1:0] qx,
    input  logic [game_pkg::COORD_W-1:0] qy,
    output logic                        active,
    output logic [game_pkg::COORD_W-1:0] x,
    output logic [game_pkg::COORD_W-1:0] y,
    output logic                        cover_c
);
    import game_pkg::*;

    localparam int unsigned CW = COORD_W;
    // One extra bit so x+SHOT_W / y+SHOT_H cannot wrap.
    localparam int unsigned XW = COORD_W + 1;
    localparam logic [XW-1:0] RETIRE_Y = XW'(Y_TOP + SPEED);

    logic [XW-1:0] x_w, y_w, qx_w, qy_w;

    // Slot state; kill wins, retirement is checked before subtracting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= 1'b0;
            x      <= '0;
            y      <= '0;
        end else if (kill && active) begin
            active <= 1'b0;
        end else if (clk_en) begin
            if (!play) begin
                active <= 1'b0;
            end else if (spawn) begin
                active <= 1'b1;
                x      <= spawn_x;
                y      <= CW'(SPAWN_Y);
            end else if (active) begin
                if ({1'b0, y} < RETIRE_Y) begin
                    active <= 1'b0;
                end else begin
                    y <= y - CW'(SPEED);
                end
            end
        end
    end

    // Pixel coverage test on widened coordinates.
    assign x_w  = {1'b0, x};
    assign y_w  = {1'b0, y};
    assign qx_w = {1'b0, qx};
    assign qy_w = {1'b0, qy};

    assign cover_c = active
                   && (qx_w >= x_w) && (qx_w < x_w + XW'(SHOT_W))
                   && (qy_w >= y_w) && (qy_w < y_w + XW'(SHOT_H));

endmodule

// File: rtl/shot_ctrl.sv
// Shot controller: spawns a shot at the player's x on each fire press (subject to
// scene, cooldown and a free slot), advances live shots each game tick, retires
// them at the top or on a kill request, and answers renderer coverage queries.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   clk_en              game tick pulse
//   swF                 fire switch, active-low raw level
//   scene               game scene (PLAY = 2'b01)
//   pos                 player x
//   kill_valid/kill_idx retire one slot (any cycle)
//   qx, qy              renderer query pixel
//   pix_on              registered coverage of previous-cycle query
//   active              per-slot live flags
//   shot_x, shot_y      flattened slot coordinates, slot i at [9i+8:9i]
//   fired               1-cycle pulse after a spawn tick
module shot_ctrl #(
    parameter int unsigned NSHOT    = 4,
    parameter int unsigned SPAWN_Y  = game_pkg::SPAWN_Y,
    parameter int unsigned Y_TOP    = game_pkg::Y_TOP,
    parameter int unsigned SPEED    = 2,
    parameter int unsigned COOLDOWN = 12,
    parameter int unsigned SHOT_W   = 2,
    parameter int unsigned SHOT_H   = 4,
    localparam int unsigned IDXW    = (NSHOT > 1) ? $clog2(NSHOT) : 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                clk_en,
    input  logic                                swF,
    input  logic [1:0]                          scene,
    input  logic [game_pkg::COORD_W-1:0]        pos,
    input  logic                                kill_valid,
    input  logic [IDXW-1:0]                     kill_idx,
    input  logic [game_pkg::COORD_W-1:0]        qx,
    input  logic [game_pkg::COORD_W-1:0]        qy,
    output logic                                pix_on,
    output logic [NSHOT-1:0]                    active,
    output logic [game_pkg::COORD_W*NSHOT-1:0]  shot_x,
    output logic [game_pkg::COORD_W*NSHOT-1:0]  shot_y,
    output logic                                fired
);
    import game_pkg::*;

    localparam int unsigned CW   = COORD_W;
    localparam int unsigned CDW  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    logic             fire_prev;
    logic [CDW-1:0]   cooldown;
    logic             play_c;
    logic             press_c;
    logic             spawn_c;
    logic [NSHOT-1:0] free_c;
    logic [NSHOT-1:0] lowest_free_c;
    logic [NSHOT-1:0] spawn_oh_c;
    logic [NSHOT-1:0] kill_oh_c;
    logic [NSHOT-1:0] cover_c;

    assign play_c  = (scene == SCENE_PLAY);
    assign press_c = fire_prev && !swF;

    // Free means not live at the start of the cycle; a slot being killed is still live.
    assign free_c        = ~active;
    assign lowest_free_c = free_c & (~free_c + NSHOT'(1));

    assign spawn_c    = clk_en && play_c && press_c && (cooldown == '0) && (|free_c);
    assign spawn_oh_c = spawn_c ? lowest_free_c : '0;

    // Press detection, cooldown, fired pulse and registered pixel coverage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fire_prev <= 1'b1;
            cooldown  <= '0;
            fired     <= 1'b0;
            pix_on    <= 1'b0;
        end else begin
            pix_on <= |cover_c;
            fired  <= spawn_c;
            if (clk_en) begin
                fire_prev <= swF;
                if (!play_c) begin
                    cooldown <= '0;
                end else if (spawn_c) begin
                    cooldown <= CDW'(COOLDOWN);
                end else if (cooldown != '0) begin
                    cooldown <= cooldown - CDW'(1);
                end
            end
        end
    end

    for (genvar i = 0; i < NSHOT; i++) begin : g_slot
        assign kill_oh_c[i] = kill_valid && (kill_idx == IDXW'(i));

        shot_slot #(
            .SPAWN_Y (SPAWN_Y),
            .Y_TOP   (Y_TOP),
            .SPEED   (SPEED),
            .SHOT_W  (SHOT_W),
            .SHOT_H  (SHOT_H)
        ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .clk_en  (clk_en),
            .play    (play_c),
            .spawn   (spawn_oh_c[i]),
            .kill    (kill_oh_c[i]),
            .spawn_x (pos),
            .qx      (qx),
            .qy      (qy),
            .active  (active[i]),
            .x       (shot_x[i*CW +: CW]),
            .y       (shot_y[i*CW +: CW]),
            .cover_c (cover_c[i])
        );
    end

endmodule

// File: tb/tb_shot_ctrl.sv
// Directed bench for shot_ctrl with a reference model feeding an expected-state queue.
module tb_shot_ctrl;

    localparam int NS      = 4;
    localparam int SPAWN   = 220;
    localparam int RET     = 18;
    localparam int CD      = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        swF;
    logic [1:0]  scene;
    logic [8:0]  pos;
    logic        kill_valid;
    logic [1:0]  kill_idx;
    logic [8:0]  qx;
    logic [8:0]  qy;
    logic        pix_on;
    logic [3:0]  active;
    logic [35:0] shot_x;
    logic [35:0] shot_y;
    logic        fired;

    shot_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .swF        (swF),
        .scene      (scene),
        .pos        (pos),
        .kill_valid (kill_valid),
        .kill_idx   (kill_idx),
        .qx         (qx),
        .qy         (qy),
        .pix_on     (pix_on),
        .active     (active),
        .shot_x     (shot_x),
        .shot_y     (shot_y),
        .fired      (fired)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        f;
        logic [3:0]  a;
        logic [35:0] x;
        logic [35:0] y;
    } exp_t;

    exp_t sbq[$];

    bit m_act[NS];
    int m_x[NS];
    int m_y[NS];
    int m_cd;
    bit m_prev;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_act[i] = 1'b0;
            m_x[i]   = 0;
            m_y[i]   = 0;
        end
        m_cd   = 0;
        m_prev = 1'b1;
        sbq.delete();
    endtask

    function automatic exp_t snap(input bit f);
        exp_t e;
        e.f = f;
        for (int i = 0; i < NS; i++) begin
            e.a[i]          = m_act[i];
            e.x[i*9 +: 9]   = 9'(m_x[i]);
            e.y[i*9 +: 9]   = 9'(m_y[i]);
        end
        return e;
    endfunction

    // Reference behaviour for one clock cycle; en marks a game tick.
    task automatic model_step(input bit en);
        bit old[NS];
        bit press;
        bit sp;
        bit play;
        int j;
        old   = m_act;
        play  = (scene == 2'b01);
        press = m_prev && !swF;
        if (en) m_prev = swF;
        j = -1;
        for (int i = 0; i < NS; i++) if (!old[i] && j < 0) j = i;
        sp = en && play && press && (m_cd == 0) && (j >= 0);
        for (int i = 0; i < NS; i++) begin
            if (kill_valid && (int'(kill_idx) == i) && old[i]) begin
                m_act[i] = 1'b0;
            end else if (en) begin
                if (!play) begin
                    m_act[i] = 1'b0;
                end else if (sp && i == j) begin
                    m_act[i] = 1'b1;
                    m_x[i]   = int'(pos);
                    m_y[i]   = SPAWN;
                end else if (old[i]) begin
                    if (m_y[i] < RET) m_act[i] = 1'b0;
                    else m_y[i] = m_y[i] - 2;
                end
            end
        end
        if (en) begin
            if (!play) m_cd = 0;
            else if (sp) m_cd = CD;
            else if (m_cd > 0) m_cd = m_cd - 1;
        end
        sbq.push_back(snap(sp));
    endtask

    task automatic cycle(input bit en);
        exp_t e;
        @(negedge clk);
        clk_en = en;
        model_step(en);
        @(posedge clk);
        #1;
        clk_en     = 1'b0;
        kill_valid = 1'b0;
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("fired",  64'(fired),  64'(e.f));
            chk("active", 64'(active), 64'(e.a));
            chk("shot_x", 64'(shot_x), 64'(e.x));
            chk("shot_y", 64'(shot_y), 64'(e.y));
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) cycle(1'b1);
    endtask

    task automatic clear_scene();
        scene = 2'b10;
        cycle(1'b1);
        scene = 2'b01;
    endtask

    task automatic pix_chk(input string tag, input int x, input int y, input logic want);
        @(negedge clk);
        qx = 9'(x);
        qy = 9'(y);
        @(posedge clk);
        #1;
        chk(tag, 64'(pix_on), 64'(want));
    endtask

    int fc;

    initial begin
        rst        = 1'b1;
        clk_en     = 1'b0;
        swF        = 1'b1;
        scene      = 2'b01;
        pos        = 9'd150;
        kill_valid = 1'b0;
        kill_idx   = 2'd0;
        qx         = 9'd0;
        qy         = 9'd0;
        model_reset();
        #12;
        chk("rst_active", 64'(active), 64'd0);
        chk("rst_x",      64'(shot_x), 64'd0);
        chk("rst_y",      64'(shot_y), 64'd0);
        chk("rst_pix",    64'(pix_on), 64'd0);
        chk("rst_fired",  64'(fired),  64'd0);
        @(negedge clk);
        rst = 1'b0;

        // First spawn and movement.
        cycle(1'b1);
        swF = 1'b0;
        cycle(1'b1);
        chk("spawn_fired", 64'(fired), 64'd1);
        chk("spawn_x0", 64'(shot_x[8:0]), 64'd150);
        chk("spawn_y0", 64'(shot_y[8:0]), 64'd220);
        ticks(3);
        chk("move_y0", 64'(shot_y[8:0]), 64'd214);

        // Holding fire gives no further spawns.
        fc = 0;
        for (int k = 0; k < 50; k++) begin
            cycle(1'b1);
            fc += int'(fired);
        end
        chk("hold_no_respawn", 64'(fc), 64'd0);

        // Cooldown drops an early press.
        clear_scene();
        swF = 1'b1; cycle(1'b1);
        swF = 1'b0; cycle(1'b1);
        chk("cd_first", 64'(fired), 64'd1);
        swF = 1'b1; ticks(7);
        swF = 1'b0; cycle(1'b1);
        chk("cd_dropped", 64'(fired), 64'd0);
        swF = 1'b1; ticks(4);
        swF = 1'b0; cycle(1'b1);
        chk("cd_second", 64'(fired), 64'd1);
        chk("cd_slots", 64'(active), 64'b0011);

        // Retirement at the top.
        clear_scene();
        pos = 9'd80;
        swF = 1'b1; cycle(1'b1);
        swF = 1'b0; cycle(1'b1);
        swF = 1'b1;
        ticks(102);
        chk("top_y", 64'(shot_y[8:0]), 64'd16);
        chk("top_live", 64'(active[0]), 64'd1);
        cycle(1'b1);
        chk("top_retired", 64'(active[0]), 64'd0);
        chk("top_y_held", 64'(shot_y[8:0]), 64'd16);

        // All slots full, dropped press, kill and refill.
        clear_scene();
        for (int s = 0; s < NS; s++) begin
            pos = 9'($urandom_range(64, 208));
            swF = 1'b1; cycle(1'b1);
            swF = 1'b0; cycle(1'b1);
            chk("fill_fired", 64'(fired), 64'd1);
            swF = 1'b1; ticks(11);
        end
        chk("fill_all", 64'(active), 64'b1111);
        cycle(1'b1);
        swF = 1'b0; cycle(1'b1);
        chk("full_drop", 64'(fired), 64'd0);
        kill_valid = 1'b1; kill_idx = 2'd2;
        cycle(1'b0);
        chk("kill2", 64'(active), 64'b1011);
        kill_valid = 1'b1; kill_idx = 2'd2;
        cycle(1'b0);
        chk("kill_inactive", 64'(active), 64'b1011);
        swF = 1'b1; ticks(12);
        pos = 9'd100;
        swF = 1'b0; cycle(1'b1);
        chk("refill_fired", 64'(fired), 64'd1);
        chk("refill_slot2", 64'(active), 64'b1111);
        chk("refill_x2", 64'(shot_x[26:18]), 64'd100);
        swF = 1'b1;
        kill_valid = 1'b1; kill_idx = 2'd0;
        cycle(1'b1);
        chk("kill_on_tick", 64'(active[0]), 64'd0);

        // Pixel coverage.
        clear_scene();
        pos = 9'd150;
        swF = 1'b1; cycle(1'b1);
        swF = 1'b0; cycle(1'b1);
        swF = 1'b1;
        ticks(60);
        chk("pix_y", 64'(shot_y[8:0]), 64'd100);
        pix_chk("pix_in",      151, 103, 1'b1);
        pix_chk("pix_x_edge",  152, 103, 1'b0);
        pix_chk("pix_y_edge",  151, 104, 1'b0);
        pix_chk("pix_corner",  150, 100, 1'b1);
        pix_chk("pix_x_left",  149, 100, 1'b0);
        pix_chk("pix_y_above", 151,  99, 1'b0);

        // Scene change clears live shots.
        clear_scene();
        for (int s = 0; s < 3; s++) begin
            swF = 1'b1; cycle(1'b1);
            swF = 1'b0; cycle(1'b1);
            swF = 1'b1; ticks(11);
        end
        chk("scene_three", 64'(active), 64'b0111);
        scene = 2'b10;
        cycle(1'b1);
        chk("scene_clear", 64'(active), 64'd0);

        // Press held across the return to PLAY does not fire.
        swF = 1'b0; cycle(1'b1);
        scene = 2'b01;
        cycle(1'b1);
        chk("scene_held", 64'(fired), 64'd0);

        // Asynchronous reset mid-tick.
        swF = 1'b1; cycle(1'b1);
        swF = 1'b0; cycle(1'b1);
        chk("pre_rst_fired", 64'(fired), 64'd1);
        @(negedge clk);
        clk_en = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_active", 64'(active), 64'd0);
        chk("arst_x",      64'(shot_x), 64'd0);
        chk("arst_y",      64'(shot_y), 64'd0);
        chk("arst_fired",  64'(fired),  64'd0);
        chk("arst_pix",    64'(pix_on), 64'd0);
        clk_en = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        swF = 1'b1; cycle(1'b1);
        swF = 1'b0; cycle(1'b1);
        chk("post_rst_fire", 64'(fired), 64'd1);
        ticks(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
